// File: rtl/arbiter_8_v_if.sv
// rtl/arbiter_8_v_if.sv - request/grant bundle between requesters and arbiter_8_v
//
// Signals:
//   i_req      [7:0] request vector, one bit per requester (level)
//   i_release        current owner finished its use of the resource
//   o_gnt      [7:0] one-hot grant, all zeros when idle
//   o_gnt_code [2:0] binary index of the owner, held while idle
//   o_gnt_v          grant active (OR of o_gnt)
//   o_timeout        one-cycle pulse on hold-limit forced release
// Modports: master = requester side, slave = arbiter side.
interface arbiter_8_v_if;
  logic [7:0] i_req;
  logic       i_release;
  logic [7:0] o_gnt;
  logic [2:0] o_gnt_code;
  logic       o_gnt_v;
  logic       o_timeout;

  modport master (
    output i_req, i_release,
    input  o_gnt, o_gnt_code, o_gnt_v, o_timeout
  );

  modport slave (
    input  i_req, i_release,
    output o_gnt, o_gnt_code, o_gnt_v, o_timeout
  );
endinterface

// File: rtl/arbiter_8_v.sv
// rtl/arbiter_8_v.sv - eight-requester arbiter with registered grant and hold limit
//
// Ports:
//   i_clk    single clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      arbiter_8_v_if.slave: i_req, i_release in; o_gnt, o_gnt_code,
//            o_gnt_v, o_timeout out (all outputs are flop outputs)
// Parameters:
//   HOLD_MAX  maximum cycles a grant may be held (1 .. 2**CNT_W-1)
//   CNT_W     hold counter width
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined: rotating priority, last owner lowest;
//                       undefined: fixed priority, highest index wins.
module arbiter_8_v #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input logic          i_clk,
  input logic          i_rst_n,
  arbiter_8_v_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_MAX - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       gnt_q;
  logic [2:0]       code_q;
  logic             gnt_v_q;
  logic             timeout_q;

  logic [2:0]       win_code;
  logic             win_v;

  logic             owner_req;
  logic             limit_hit;
  logic             release_now;

`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] rr_ptr;
  logic [2:0] idx;

  // Search order is ptr-1, ptr-2, ..., ptr (mod 8). Walk it backwards so the
  // last assignment made belongs to the highest-priority set request.
  always_comb begin
    win_code = 3'd0;
    idx      = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      idx = rr_ptr - 3'(i);
      if (bus.i_req[idx]) win_code = idx;
    end
  end
`else
  // Fixed priority: ascending scan, so the highest set index is written last.
  always_comb begin
    win_code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.i_req[i]) win_code = 3'(i);
    end
  end
`endif

  assign win_v       = |bus.i_req;
  assign owner_req   = bus.i_req[code_q];
  assign limit_hit   = (cnt == HOLD_LIMIT);
  assign release_now = bus.i_release || !owner_req || limit_hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      gnt_q     <= 8'h00;
      code_q    <= 3'd0;
      gnt_v_q   <= 1'b0;
      timeout_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr    <= 3'd0;
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_v) begin
            state   <= GRANT;
            gnt_q   <= 8'd1 << win_code;
            code_q  <= win_code;
            gnt_v_q <= 1'b1;
            cnt     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr  <= win_code;
`endif
          end
        end
        GRANT: begin
          if (release_now) begin
            state     <= IDLE;
            gnt_q     <= 8'h00;
            gnt_v_q   <= 1'b0;
            // Timeout only when the limit is the sole reason for release.
            timeout_q <= limit_hit && !bus.i_release && owner_req;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_gnt      = gnt_q;
  assign bus.o_gnt_code = code_q;
  assign bus.o_gnt_v    = gnt_v_q;
  assign bus.o_timeout  = timeout_q;

endmodule

// File: doc/arbiter_8_v.md
# arbiter_8_v

Eight-requester arbiter that shares a single downstream resource (bus port, MUX datapath, encoder output) between requesters `i_req[7:0]`. Selection is made by an 8:3 priority-encode stage; the grant is then registered and held by a small FSM until the owner releases, drops its request, or exceeds a hold limit. The block sits between requesting units and the shared datapath, driving both a one-hot grant and the encoded 3-bit grant index used as the datapath select.

## Interface
- `HOLD_MAX`, default 15: maximum cycles a grant may be held before forced release. Legal range 1..(2^`CNT_W` − 1).
- `CNT_W`, default 4: width of the hold counter.

Ports:
- `i_clk` input 1: single clock. All state updates on its rising edge.
- `i_rst_n` input 1: reset, asynchronous, active-low.
- `i_req` input 8: request vector, one bit per requester. Level-sensitive.
- `i_release` input 1: the current owner finishes its use. Ignored outside GRANT.
- `o_gnt` output 8: one-hot grant, registered. All zeros when no grant.
- `o_gnt_code` output 3: binary index of the granted requester, registered. Held at its last value when `o_gnt_v`=0.
- `o_gnt_v` output 1: a grant is active. Equals OR of `o_gnt`.
- `o_timeout` output 1: one-cycle pulse when a grant is force-released by the hold limit.

## Operation
- **FSM states**
  - IDLE: no grant; arbitrates every cycle.
  - GRANT: one requester owns the resource.
- **Reset values**
  - State IDLE; `o_gnt`=8'h00; `o_gnt_code`=3'b000; `o_gnt_v`=0; `o_timeout`=0.
  - Hold counter 0; round-robin pointer 3'd0.
- **IDLE → GRANT** when `i_req`≠0. Winner k is loaded into `o_gnt` (bit k), `o_gnt_code` (=k), and `o_gnt_v`=1. Counter is cleared to 0.
- **IDLE → IDLE** when `i_req`=0. Outputs stay deasserted.
- **GRANT**
  - Counter increments each cycle.
  - Release condition is any of: `i_release`=1; `i_req[k]`=0; or counter = `HOLD_MAX`−1.
  - On release: next state IDLE, `o_gnt`=0, `o_gnt_v`=0.
  - `o_timeout`=1 for one cycle only when the hold limit is the sole release cause. If `i_release` or a request drop occurs in the same cycle, no timeout pulse.
- **Winner selection, fixed priority** (default): highest set index wins. 8'b0010_0110 → k=5.
- **Requests during GRANT**: changes in other requesters' bits do not preempt the owner. They are evaluated in the next IDLE cycle.
- **Reset mid-grant**: all outputs are cleared immediately, asynchronously. No timeout pulse is generated.

## Timing
- **Grant latency**: request seen in IDLE at edge n → `o_gnt`/`o_gnt_code`/`o_gnt_v` valid after edge n (registered, 1 cycle).
- **Release latency**: release condition at edge n → `o_gnt_v`=0 after edge n.
- **Minimum gap between grants**: one IDLE cycle, so back-to-back grants are ≥2 cycles apart edge-to-edge.
- **Maximum hold**: `HOLD_MAX` cycles with `o_gnt_v`=1. The `o_timeout` pulse coincides with the first cycle of `o_gnt_v`=0.
- **Output stability**: all outputs are flop outputs. There is no combinational path from `i_req` or `i_release` to outputs.

## Configuration
- **Macro `ARB_ROUND_ROBIN_EN`**
- **Defined**: rotating priority.
  - The pointer updates to the granted index k on every IDLE→GRANT transition.
  - Search order is k−1, k−2, …, 0, 7, …, k (mod 8), with the first set bit winning. The last owner therefore has lowest priority.
  - At reset the pointer is 0, so the order is 7..0, identical to fixed priority.
  - On timeout the pointer is still k, so the timed-out owner has lowest priority next round.
- **Undefined**: fixed priority, highest index first. No pointer register exists.

## Test plan
- Reset then `i_req`=8'h00 for 10 cycles → `o_gnt_v`=0, `o_gnt`=8'h00, `o_gnt_code`=0 throughout. Assert `i_rst_n`=0 mid-grant → all outputs 0 asynchronously.
- `i_req`=8'b0010_0110 in IDLE → one cycle later `o_gnt`=8'h20, `o_gnt_code`=5. `i_release` pulse → `o_gnt_v`=0 next cycle. With `i_req` held, re-grant to 5 after one IDLE cycle (fixed priority).
- Grant to 3, then deassert `i_req[3]` while `i_req[6]` rises → grant drops next cycle, `o_gnt_code`=6 one cycle later. No `o_timeout`.
- `HOLD_MAX`=4, `i_req`=8'h01 held, no release → `o_gnt_v`=1 for exactly 4 cycles, then `o_timeout`=1 for 1 cycle, then re-grant to 0.
- Same as the hold-limit scenario, but `i_release` is asserted on the limit cycle → release occurs, `o_timeout` stays 0.
- `ARB_ROUND_ROBIN_EN`, `i_req`=8'hFF held, release each grant → `o_gnt_code` sequence 7,6,5,4,3,2,1,0,7. Without the macro the sequence is 7,7,7,…
